// File: rtl/multdiv_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package multdiv_pkg;
  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
endpackage

// File: rtl/multdiv_addsub.sv
// (WIDTH+1)-bit adder/subtractor; the single arithmetic datapath of the unit.
module multdiv_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);
  logic [WIDTH:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub_i};
endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit.
// One add/sub per cycle; result and exception registered on the DONE->IDLE edge.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  localparam int PW = 2*WIDTH + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;

  logic [WIDTH:0]   as_a, as_b, as_sum;
  logic             as_sub, as_cout;
  logic [WIDTH-1:0] hi, lo, rem_sh, a_mag, b_mag;

  // prod_q: {hi / remainder, lo / multiplier-quotient, Booth q(-1)}
  assign hi     = prod_q[PW-1:WIDTH+1];
  assign lo     = prod_q[WIDTH:1];
  assign rem_sh = {prod_q[PW-2:WIDTH+1], prod_q[WIDTH]};
  assign a_mag  = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign b_mag  = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  always_comb begin
    as_a   = '0;
    as_b   = '0;
    as_sub = 1'b0;
    case (state_q)
      MULT: begin
        as_a   = {hi[WIDTH-1], hi};
        as_sub = (prod_q[1:0] == 2'b10);
        if (prod_q[1] ^ prod_q[0]) as_b = {mcand_q[WIDTH-1], mcand_q};
      end
      DIV: begin
        as_a   = {1'b0, rem_sh};
        as_b   = {1'b0, mcand_q};
        as_sub = 1'b1;
      end
      // Sign fix-up reuses the adder: 0 - quotient
      DONE: begin
        as_b   = {1'b0, lo};
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  multdiv_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a_i    (as_a),
    .b_i    (as_b),
    .sub_i  (as_sub),
    .sum_o  (as_sum),
    .cout_o (as_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    res_d    = res_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_MULT | ctrl_DIV) begin
      cnt_d    = '0;
      is_div_d = ~ctrl_MULT;
      if (ctrl_MULT) begin
        state_d = MULT;
        prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
        mcand_d = data_operandA;
      end else begin
        state_d = DIV;
        prod_d  = {{WIDTH{1'b0}}, a_mag, 1'b0};
        mcand_d = b_mag;
        neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz_d    = (data_operandB == '0);
      end
    end else begin
      case (state_q)
        MULT, DIV: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d = DONE;
            cnt_d   = '0;
          end
          if (state_q == MULT)
            prod_d = {as_sum, prod_q[WIDTH:1]};
          else if (as_cout)
            prod_d = {as_sum[WIDTH-1:0], prod_q[WIDTH-1:1], 1'b1, 1'b0};
          else
            prod_d = {rem_sh, prod_q[WIDTH-1:1], 1'b0, 1'b0};
        end
        DONE: begin
          state_d = IDLE;
          rdy_d   = 1'b1;
          if (!is_div_q) begin
            res_d = lo;
            exc_d = ~((&prod_q[PW-1:WIDTH]) | ~(|prod_q[PW-1:WIDTH]));
          end else if (dz_q) begin
            res_d = '0;
            exc_d = 1'b1;
          end else begin
            // Only MIN / -1 yields an unsigned quotient with MSB set and positive sign
            res_d = neg_q ? as_sum[WIDTH-1:0] : lo;
            exc_d = ~neg_q & lo[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      res_q    <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      res_q    <= res_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
endmodule

// File: tb/tb_multdiv_iter.sv
// Directed bench for multdiv_iter: latency, results, exceptions, abort and reset.
module tb_multdiv_iter;
  logic        clock;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int checks = 0;
  int errors = 0;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0 = MULT, 1 = DIV, 2 = both strobes; the strobe edge is the next posedge
  task automatic launch(input int mode, input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = (mode != 1);
    ctrl_DIV      = (mode != 0);
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic watch(input int n, output int cnt, output int at,
                       output logic [31:0] r, output logic e);
    cnt = 0; at = -1; r = 'x; e = 1'bx;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        cnt++;
        if (at < 0) begin
          at = i; r = data_result; e = data_exception;
        end
      end
    end
  endtask

  task automatic run(input string tag, input int mode, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_r, input logic exp_e);
    int cnt, at;
    logic [31:0] r;
    logic e;
    launch(mode, a, b);
    watch(40, cnt, at, r, e);
    check({tag, "_rdy_count"}, cnt, 1);
    check({tag, "_rdy_edge"}, at, 33);
    check({tag, "_result"}, r, exp_r);
    check({tag, "_exc"}, {31'b0, e}, {31'b0, exp_e});
    check({tag, "_hold"}, data_result, exp_r);
  endtask

  initial begin
    int cnt, at;
    logic [31:0] r;
    logic e;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", data_result, 32'h0);
    check("reset_exc", {31'b0, data_exception}, 32'h0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    run("mul_7xm3",      0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    run("mul_ovf",       0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);
    run("mul_min_x1",    0, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0);
    run("mul_m1xm1",     0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run("mul_2p31",      0, 32'h4000_0000, 32'd2,        32'h8000_0000, 1'b1);
    run("both_mult_wins",2, 32'd6,        32'd7,        32'h0000_002A, 1'b0);
    run("div_m7_2",      1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0);
    run("div_100_m10",   1, 32'd100,      32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0);
    run("div_by_zero",   1, 32'd5,        32'd0,        32'h0000_0000, 1'b1);
    run("div_min_m1",    1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    run("div_min_1",     1, 32'h8000_0000, 32'd1,        32'h8000_0000, 1'b0);

    // Abort: MULT at edge k, DIV restarts at edge k+10
    launch(0, 32'd3, 32'd4);
    watch(9, cnt, at, r, e);
    check("abort_pre_rdy", cnt, 0);
    launch(1, 32'd20, 32'd4);
    watch(40, cnt, at, r, e);
    check("abort_rdy_count", cnt, 1);
    check("abort_rdy_edge", at, 33);
    check("abort_result", r, 32'd5);
    check("abort_exc", {31'b0, e}, 32'h0);

    // Reset in the middle of a multiply
    launch(0, 32'd5, 32'd6);
    watch(14, cnt, at, r, e);
    reset = 1'b1;
    #1;
    check("midreset_result", data_result, 32'h0);
    check("midreset_exc", {31'b0, data_exception}, 32'h0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    watch(40, cnt, at, r, e);
    check("midreset_no_rdy", cnt, 0);
    check("midreset_result_idle", data_result, 32'h0);
    run("post_reset_2x2", 0, 32'd2, 32'd2, 32'h0000_0004, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
